dmem_responder: RTL and testbench

Data-memory responder for the CPU's data port: the memory-side end of the load/store interface that the core drives for LDUR/STUR. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs a sized, little-endian read or write on an internal word array, and returns a response over a second valid/ready handshake. It lets the same core be run against a memory with realistic multi-cycle latency and error signalling.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes,
// FSM states and the byte-lane mask used for sized stores.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte enables for an access of the given size starting at a byte lane.
    // Only meaningful for aligned accesses, which never spill past lane 7.
    function automatic logic [7:0] byteMask(input size_e size, input logic [2:0] offset);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << offset;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit word storage with a byte-enable write port and an
// asynchronous read port sharing one index. Contents survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [7:0]        i_byteEn,
    input  logic [63:0]       i_wdata,
    output logic [63:0]       o_rdata
);

    logic [63:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (i_byteEn[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core's load/store port: one request at a time,
// programmable wait states, sized little-endian access, error signalling.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    state_e             r_state, w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_addr, r_wdata, r_rdata;
    logic               r_wr, r_err;
    size_e              r_size;

    logic [2:0]         w_offset;
    logic               w_misaligned, w_outOfRange, w_err, w_execute;
    logic [IDX_W-1:0]   w_idx;
    logic [63:0]        w_rdWord, w_sizeMask, w_loadData, w_wdataLane;
    logic [7:0]         w_byteEn;

    assign w_offset     = r_addr[2:0];
    assign w_idx        = r_addr[IDX_W+2:3];
    assign w_outOfRange = r_addr[63:3] >= 61'(DEPTH);

    always_comb begin
        w_misaligned = 1'b0;
        w_sizeMask   = '1;
        case (r_size)
            SZ_B: w_sizeMask = 64'h0000_0000_0000_00FF;
            SZ_H: begin
                w_misaligned = r_addr[0];
                w_sizeMask   = 64'h0000_0000_0000_FFFF;
            end
            SZ_W: begin
                w_misaligned = |r_addr[1:0];
                w_sizeMask   = 64'h0000_0000_FFFF_FFFF;
            end
            default: w_misaligned = |r_addr[2:0];
        endcase
    end

    assign w_err       = w_misaligned | w_outOfRange;
    assign w_execute   = (r_state == WAIT) && (r_cnt == '0);
    assign w_loadData  = (w_rdWord >> {w_offset, 3'b000}) & w_sizeMask;
    assign w_wdataLane = r_wdata << {w_offset, 3'b000};
    // Reset on the execute edge must suppress the store along with the response.
    assign w_byteEn    = (w_execute && r_wr && !w_err && !rst) ? byteMask(r_size, w_offset) : 8'h00;

    dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk      (clk),
        .i_idx    (w_idx),
        .i_byteEn (w_byteEn),
        .i_wdata  (w_wdataLane),
        .o_rdata  (w_rdWord)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) w_nextState = WAIT;
            end
            WAIT: if (r_cnt == '0) w_nextState = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_size  <= SZ_B;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_wr    <= req_wr;
                    r_size  <= size_e'(req_size);
                    r_wdata <= req_wdata;
                    r_cnt   <= CNT_W'(WAIT_STATES);
                end
                WAIT: if (r_cnt == '0) begin
                    r_err   <= w_err;
                    r_rdata <= (w_err || r_wr) ? 64'h0 : w_loadData;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                RESP: if (resp_ready) begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset corner
// sequences, and randomized traffic checked against a byte-addressed model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    int errCnt = 0;
    int chkCnt = 0;

    logic [7:0] mdlMem [longint];

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] expData;
        bit          expErr;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, access of 2^size bytes at addr.
    task automatic modelAccess(input bit wr, input int size, input logic [63:0] addr,
                               input logic [63:0] wdata, output logic [63:0] expData, output bit expErr);
        longint unsigned a = addr;
        longint unsigned n = 64'd1 << size;
        expErr  = ((a % n) != 0) || ((a / 8) >= DEPTH);
        expData = 64'h0;
        if (!expErr) begin
            for (int i = 0; i < int'(n); i++) begin
                if (wr) mdlMem[longint'(a) + i] = wdata[8*i +: 8];
                else if (mdlMem.exists(longint'(a) + i)) expData[8*i +: 8] = mdlMem[longint'(a) + i];
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input bit wr, input logic [1:0] size,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] expData, input bit expErr, input int hold);
        int n;
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput({tag, " accept timeout"}, 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(WS + 1));
        if (!resp_valid) return;
        for (int h = 0; h <= hold; h++) begin
            checkOutput({tag, " rdata"}, resp_rdata, expData);
            checkOutput({tag, " err"}, 64'(resp_err), 64'(expErr));
            checkOutput({tag, " valid held"}, 64'(resp_valid), 64'd1);
            checkOutput({tag, " req_ready busy"}, 64'(req_ready), 64'd0);
            if (h < hold) begin
                @(posedge clk);
                #1;
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput({tag, " valid cleared"}, 64'(resp_valid), 64'd0);
        checkOutput({tag, " idle ready"}, 64'(req_ready), 64'd1);
        checkOutput({tag, " rdata cleared"}, resp_rdata, 64'h0);
        checkOutput({tag, " err cleared"}, 64'(resp_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] ed;
        bit          ee;
        int          n;
        bit          wr;
        logic [1:0]  sz;
        logic [63:0] addr, wdata;

        vecs.push_back(vec_t'{1'b1, 2'd3, 64'h10,   64'h1122334455667788, 64'h0,                 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 2'd3, 64'h10,   64'h0,                64'h1122334455667788,  1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 2'd0, 64'h13,   64'hFFFFFFFFFFFFFFAA, 64'h0,                 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 2'd3, 64'h10,   64'h0,                64'h11223344AA667788,  1'b0, 5});
        vecs.push_back(vec_t'{1'b0, 2'd1, 64'h12,   64'h0,                64'h000000000000AA66,  1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 2'd2, 64'h16,   64'h0,                64'h0,                 1'b1, 0});
        vecs.push_back(vec_t'{1'b1, 2'd3, 64'h14,   64'hFFFFFFFFFFFFFFFF, 64'h0,                 1'b1, 0});
        vecs.push_back(vec_t'{1'b0, 2'd3, 64'h10,   64'h0,                64'h11223344AA667788,  1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 2'd3, 64'h1FF8, 64'h0123456789ABCDEF, 64'h0,                 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 2'd3, 64'h1FF8, 64'h0,                64'h0123456789ABCDEF,  1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 2'd3, 64'h2000, 64'h0,                64'h0,                 1'b1, 0});
        vecs.push_back(vec_t'{1'b1, 2'd3, 64'h20,   64'hCAFEF00D12345678, 64'h0,                 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 2'd2, 64'h24,   64'h0,                64'h00000000CAFEF00D,  1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 2'd0, 64'h17,   64'h0,                64'h0000000000000011,  1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 2'd1, 64'h11,   64'h0,                64'h0,                 1'b1, 0});

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset rdata", resp_rdata, 64'h0);
        checkOutput("reset err", 64'(resp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post-reset req_ready", 64'(req_ready), 64'd1);

        foreach (vecs[i]) begin
            modelAccess(vecs[i].wr, int'(vecs[i].size), vecs[i].addr, vecs[i].wdata, ed, ee);
            applyStimulus($sformatf("dir%0d", i), vecs[i].wr, vecs[i].size, vecs[i].addr,
                          vecs[i].wdata, vecs[i].expData, vecs[i].expErr, vecs[i].hold);
        end

        // Reset while a store waits: the store must never land.
        @(negedge clk);
        checkOutput("rstWait idle before", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_size  = 2'd3;
        req_addr  = 64'h20;
        req_wdata = 64'hDEAD;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstWait resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rstWait req_ready", 64'(req_ready), 64'd0);
        checkOutput("rstWait rdata", resp_rdata, 64'h0);
        checkOutput("rstWait err", 64'(resp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstWait ready after", 64'(req_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rstWait no late resp", 64'(resp_valid), 64'd0);
        modelAccess(1'b0, 3, 64'h20, 64'h0, ed, ee);
        applyStimulus("rstWait reload", 1'b0, 2'd3, 64'h20, 64'h0, 64'hCAFEF00D12345678, 1'b0, 0);

        // Reset while a response is presented, racing a consumer handshake.
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_size  = 2'd3;
        req_addr  = 64'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rstResp reached RESP", 64'(resp_valid), 64'd1);
        @(negedge clk);
        rst        = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstResp resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rstResp rdata", resp_rdata, 64'h0);
        @(negedge clk);
        rst        = 1'b0;
        resp_ready = 1'b0;
        #1;
        checkOutput("rstResp ready after", 64'(req_ready), 64'd1);

        // Randomized traffic over a small window plus the top-of-range word.
        for (int w = 0; w < 8; w++) begin
            wdata = {$urandom, $urandom};
            modelAccess(1'b1, 3, 64'(8 * w), wdata, ed, ee);
            applyStimulus($sformatf("init%0d", w), 1'b1, 2'd3, 64'(8 * w), wdata, ed, ee, 0);
        end
        wdata = {$urandom, $urandom};
        modelAccess(1'b1, 3, 64'h1FF8, wdata, ed, ee);
        applyStimulus("initTop", 1'b1, 2'd3, 64'h1FF8, wdata, ed, ee, 0);

        for (int r = 0; r < 150; r++) begin
            wr    = 1'($urandom_range(0, 1));
            sz    = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 4) == 0) ? 64'h1FF8 + 64'($urandom_range(0, 15))
                                                : 64'($urandom_range(0, 63));
            wdata = {$urandom, $urandom};
            modelAccess(wr, int'(sz), addr, wdata, ed, ee);
            applyStimulus($sformatf("rnd%0d", r), wr, sz, addr, wdata, ed, ee, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
